// File: rtl/pipeexe_md.sv
`default_nettype none
// ============================================================================
// Module   : pipeexe_md
// Purpose  : Execute stage with combinational ALU and jal link path, plus an
//            iterative MULTU/DIVU unit that owns HI/LO and requests stalls.
// Revision : 1.0  initial release
// ============================================================================
module pipeexe_md #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       ealuc,
    input  logic             ealuimm,
    input  logic             eshift,
    input  logic             ejal,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic [WIDTH-1:0] eimm,
    input  logic [WIDTH-1:0] esa,
    input  logic [WIDTH-1:0] epc4,
    input  logic [4:0]       ern0,
    input  logic             emd_start,
    input  logic [1:0]       emd_op,
    input  logic             emfhi,
    input  logic             emflo,
    output logic [WIDTH-1:0] ealu,
    output logic [4:0]       ern,
    output logic             estall,
    output logic             ebusy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_SH_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_ph;
    logic [WIDTH-1:0] r_pl;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [c_SH_W-1:0] w_sh;
    logic [WIDTH-1:0]  w_alu;

    assign w_a  = eshift  ? esa  : ea;
    assign w_b  = ealuimm ? eimm : eb;
    assign w_sh = w_a[c_SH_W-1:0];

    always_comb begin
        w_alu = '0;
        case (ealuc[1:0])
            2'b00:   w_alu = ealuc[2] ? (w_a - w_b) : (w_a + w_b);
            2'b01:   w_alu = ealuc[2] ? (w_a | w_b) : (w_a & w_b);
            2'b10:   w_alu = ealuc[2] ? (w_b << (WIDTH/2)) : (w_a ^ w_b);
            default: begin
                if (!ealuc[2])
                    w_alu = w_b << w_sh;
                else if (!ealuc[3])
                    w_alu = w_b >> w_sh;
                else
                    w_alu = $signed(w_b) >>> w_sh;
            end
        endcase
    end

    always_comb begin
        if (ejal)
            ealu = epc4 + WIDTH'(4);
        else if (emfhi)
            ealu = r_hi;
        else if (emflo)
            ealu = r_lo;
        else
            ealu = w_alu;
    end

    assign ern    = ern0 | {5{ejal}};
    assign ebusy  = (r_state == ST_RUN);
    assign estall = ebusy & (emd_start | emfhi | emflo);
    assign hi     = r_hi;
    assign lo     = r_lo;

    // Multiply step: {r_ph,r_pl} is the partial product, r_pl shifting out the multiplier.
    logic [WIDTH-1:0] w_madd;
    logic [WIDTH:0]   w_msum;
    logic [WIDTH-1:0] w_mh;
    logic [WIDTH-1:0] w_ml;

    assign w_madd = r_pl[0] ? r_a : {WIDTH{1'b0}};
    assign w_msum = {1'b0, r_ph} + {1'b0, w_madd};
    assign w_mh   = w_msum[WIDTH:1];
    assign w_ml   = {w_msum[0], r_pl[WIDTH-1:1]};

    // Divide step: r_ph is the partial remainder, r_pl shifts dividend out and quotient in.
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_dh;
    logic [WIDTH-1:0] w_dl;

    assign w_shl  = {r_ph, r_pl[WIDTH-1]};
    assign w_diff = w_shl - {1'b0, r_b};
    assign w_ge   = (w_shl >= {1'b0, r_b});
    assign w_dh   = w_ge ? w_diff[WIDTH-1:0] : w_shl[WIDTH-1:0];
    assign w_dl   = {r_pl[WIDTH-2:0], w_ge};

    logic [WIDTH-1:0] w_nh;
    logic [WIDTH-1:0] w_nl;
    logic             w_last;

    assign w_nh   = r_op ? w_dh : w_mh;
    assign w_nl   = r_op ? w_dl : w_ml;
    assign w_last = (r_cnt == CNT_W'(WIDTH-1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_ph    <= '0;
            r_pl    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (r_state == ST_IDLE) begin
            if (emd_start && !emd_op[1]) begin
                r_state <= ST_RUN;
                r_cnt   <= '0;
                r_op    <= emd_op[0];
                r_a     <= ea;
                r_b     <= eb;
                r_ph    <= '0;
                r_pl    <= emd_op[0] ? ea : eb;
            end
        end else begin
            r_ph  <= w_nh;
            r_pl  <= w_nl;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                if (r_op && (r_b == '0)) begin
                    r_hi <= r_a;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_nh;
                    r_lo <= w_nl;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeexe_md.sv
`default_nettype none
// Testbench for pipeexe_md: randomized and directed stimulus against a plain
// arithmetic model of the ALU, result select and MULTU/DIVU behaviour.
module tb_pipeexe_md;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [3:0]    ealuc;
    logic          ealuimm, eshift, ejal;
    logic [W-1:0]  ea, eb, eimm, esa, epc4;
    logic [4:0]    ern0;
    logic          emd_start;
    logic [1:0]    emd_op;
    logic          emfhi, emflo;
    logic [W-1:0]  ealu, hi, lo;
    logic [4:0]    ern;
    logic          estall, ebusy;

    logic [15:0]   a16, b16, ealu16, hi16, lo16;
    logic          start16, estall16, ebusy16;
    logic [4:0]    ern16;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] m_hi, m_lo;

    always #5 clock = ~clock;

    pipeexe_md #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .ealuc(ealuc), .ealuimm(ealuimm),
        .eshift(eshift), .ejal(ejal), .ea(ea), .eb(eb), .eimm(eimm),
        .esa(esa), .epc4(epc4), .ern0(ern0), .emd_start(emd_start),
        .emd_op(emd_op), .emfhi(emfhi), .emflo(emflo), .ealu(ealu),
        .ern(ern), .estall(estall), .ebusy(ebusy), .hi(hi), .lo(lo)
    );

    pipeexe_md #(.WIDTH(16), .CNT_W(5)) dut16 (
        .clock(clock), .reset(reset), .ealuc(4'd0), .ealuimm(1'b0),
        .eshift(1'b0), .ejal(1'b0), .ea(a16), .eb(b16), .eimm(16'd0),
        .esa(16'd0), .epc4(16'd0), .ern0(5'd0), .emd_start(start16),
        .emd_op(2'b00), .emfhi(1'b0), .emflo(1'b0), .ealu(ealu16),
        .ern(ern16), .estall(estall16), .ebusy(ebusy16), .hi(hi16), .lo(lo16)
    );

    function automatic logic [63:0] md_ref(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (!op)
            return {32'd0, a} * {32'd0, b};
        else if (b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        else
            return {a % b, a / b};
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        casez (c)
            4'b?000: r = a + b;
            4'b?100: r = a - b;
            4'b?001: r = a & b;
            4'b?101: r = a | b;
            4'b?010: r = a ^ b;
            4'b?110: r = b << 16;
            4'b0011: r = b << a[4:0];
            4'b0111: r = b >> a[4:0];
            4'b1111: r = $signed(b) >>> a[4:0];
            default: r = 32'hx;
        endcase
        return r;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        ealuc = 4'd0; ealuimm = 1'b0; eshift = 1'b0; ejal = 1'b0;
        ea = '0; eb = '0; eimm = '0; esa = '0; epc4 = '0; ern0 = '0;
        emd_start = 1'b0; emd_op = 2'b00; emfhi = 1'b0; emflo = 1'b0;
        a16 = '0; b16 = '0; start16 = 1'b0;
    endtask

    // Counts edges until the unit goes idle; bounded so a stuck unit still ends.
    task automatic wait_idle(output int n);
        n = 0;
        while (ebusy && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        total++; if (ebusy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", ebusy); end
        total++; if (estall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", estall); end
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_alu_directed;
        logic [3:0]  codes [4];
        logic [31:0] exps  [4];
        codes = '{4'b0000, 4'b0100, 4'b0101, 4'b0001};
        exps  = '{32'hFF, 32'hE1, 32'hFF, 32'h0};
        idle_inputs();
        ea = 32'h0000_00F0; eb = 32'h0000_000F; ern0 = 5'd7;
        for (int i = 0; i < 4; i++) begin
            ealuc = codes[i];
            #1;
            total++;
            if (ealu !== exps[i]) begin bad++; $display("FAIL alu_dir code=%b: got %h want %h", codes[i], ealu, exps[i]); end
        end
        total++; if (ern !== 5'd7) begin bad++; $display("FAIL ern_pass: got %0d want 7", ern); end
        ealuc = 4'b1111; eshift = 1'b1; esa = 32'd4; eb = 32'h8000_0000;
        #1;
        total++; if (ealu !== 32'hF800_0000) begin bad++; $display("FAIL alu_sra: got %h want f8000000", ealu); end
        ejal = 1'b1; epc4 = 32'h100;
        #1;
        total++; if (ealu !== 32'h104) begin bad++; $display("FAIL jal_link: got %h want 104", ealu); end
        total++; if (ern !== 5'd31) begin bad++; $display("FAIL jal_ern: got %0d want 31", ern); end
        idle_inputs();
    endtask

    task automatic run_md(input string name, input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        idle_inputs();
        ea = a; eb = b; emd_op = {1'b0, op}; emd_start = 1'b1;
        #1;
        total++; if (estall !== 1'b0) begin bad++; $display("FAIL %s idle_stall: got %b want 0", name, estall); end
        tick();
        emd_start = 1'b0;
        ea = $urandom; eb = $urandom;
        wait_idle(n);
        total++; if (n != W) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, n, W); end
        total++; if (hi !== ehi) begin bad++; $display("FAIL %s hi: got %h want %h", name, hi, ehi); end
        total++; if (lo !== elo) begin bad++; $display("FAIL %s lo: got %h want %h", name, lo, elo); end
        m_hi = ehi;
        m_lo = elo;
    endtask

    task automatic test_multu_stall;
        int stalls;
        idle_inputs();
        ea = 32'hFFFF_FFFF; eb = 32'd2; emd_start = 1'b1;
        tick();
        emd_start = 1'b0; emfhi = 1'b1;
        #1;
        stalls = 0;
        while (estall === 1'b1 && stalls < 100) begin
            stalls++;
            tick();
        end
        total++; if (stalls != W) begin bad++; $display("FAIL mfhi_stall_cycles: got %0d want %0d", stalls, W); end
        total++; if (hi !== 32'h1) begin bad++; $display("FAIL multu_hi: got %h want 1", hi); end
        total++; if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
        total++; if (ealu !== 32'h1) begin bad++; $display("FAIL mfhi_result: got %h want 1", ealu); end
        m_hi = 32'h1;
        m_lo = 32'hFFFF_FFFE;
        idle_inputs();
    endtask

    task automatic test_md_random;
        logic [63:0] r;
        logic [31:0] a, b;
        logic        op;
        run_md("divu_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
        run_md("divu_by0", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            op = i[0];
            a  = $urandom;
            b  = (i == 5) ? ($urandom & 32'hFF) : $urandom;
            r  = md_ref(op, a, b);
            run_md(op ? "divu_rand" : "multu_rand", op, a, b, r[63:32], r[31:0]);
        end
    endtask

    task automatic test_alu_random;
        logic [3:0]  codes [15];
        logic [31:0] oa, ob, exp;
        logic [4:0]  exprn;
        codes = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd1, 4'd9, 4'd5, 4'd13, 4'd2, 4'd10, 4'd6, 4'd14, 4'd3, 4'd7, 4'd15};
        for (int i = 0; i < 60; i++) begin
            idle_inputs();
            ealuc = codes[$urandom_range(14)];
            ea = $urandom; eb = $urandom; eimm = $urandom; esa = $urandom; epc4 = $urandom;
            ern0 = 5'($urandom); eshift = 1'($urandom); ealuimm = 1'($urandom);
            ejal  = ($urandom_range(7) == 0);
            emfhi = ($urandom_range(5) == 0);
            emflo = ($urandom_range(5) == 0);
            #1;
            oa = eshift ? esa : ea;
            ob = ealuimm ? eimm : eb;
            if (ejal)       exp = epc4 + 32'd4;
            else if (emfhi) exp = m_hi;
            else if (emflo) exp = m_lo;
            else            exp = alu_ref(ealuc, oa, ob);
            exprn = ejal ? 5'd31 : ern0;
            total++; if (ealu !== exp) begin bad++; $display("FAIL alu_rand c=%b jal=%b hi=%b lo=%b: got %h want %h", ealuc, ejal, emfhi, emflo, ealu, exp); end
            total++; if (ern !== exprn) begin bad++; $display("FAIL ern_rand: got %0d want %0d", ern, exprn); end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back;
        logic [31:0] a1, b1, a2, b2;
        logic [63:0] r1, r2;
        int k, n;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        r1 = md_ref(1'b0, a1, b1);
        r2 = md_ref(1'b0, a2, b2);
        idle_inputs();
        ea = a1; eb = b1; emd_start = 1'b1;
        tick();
        emd_start = 1'b0; ealuc = 4'b0000; ea = 32'd3; eb = 32'd4;
        #1;
        total++; if (estall !== 1'b0) begin bad++; $display("FAIL overlap_stall: got %b want 0", estall); end
        total++; if (ealu !== 32'd7) begin bad++; $display("FAIL overlap_add: got %h want 7", ealu); end
        total++; if (ebusy !== 1'b1) begin bad++; $display("FAIL overlap_busy: got %b want 1", ebusy); end
        tick();
        ea = a2; eb = b2; emd_start = 1'b1;
        #1;
        k = 0;
        while (estall === 1'b1 && k < 100) begin
            k++;
            tick();
        end
        total++; if (k != W - 1) begin bad++; $display("FAIL b2b_stall_cycles: got %0d want %0d", k, W - 1); end
        total++; if (hi !== r1[63:32]) begin bad++; $display("FAIL b2b_first_hi: got %h want %h", hi, r1[63:32]); end
        total++; if (lo !== r1[31:0]) begin bad++; $display("FAIL b2b_first_lo: got %h want %h", lo, r1[31:0]); end
        tick();
        emd_start = 1'b0;
        total++; if (ebusy !== 1'b1) begin bad++; $display("FAIL b2b_no_gap: got %b want 1", ebusy); end
        wait_idle(n);
        total++; if (n != W) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", n, W); end
        total++; if ({hi, lo} !== r2) begin bad++; $display("FAIL b2b_second: got %h want %h", {hi, lo}, r2); end
        m_hi = r2[63:32];
        m_lo = r2[31:0];
        idle_inputs();
    endtask

    task automatic test_reset_abort;
        idle_inputs();
        ea = 32'd100; eb = 32'd7; emd_op = 2'b01; emd_start = 1'b1;
        tick();
        emd_start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL abort_hi: got %h want 0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL abort_lo: got %h want 0", lo); end
        total++; if (ebusy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", ebusy); end
        m_hi = '0;
        m_lo = '0;
        run_md("multu_3x5", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15);
    endtask

    task automatic test_reserved_and_jal;
        logic [31:0] a, b, pc;
        logic [63:0] r;
        int n;
        for (int op = 2; op < 4; op++) begin
            idle_inputs();
            ea = $urandom; eb = $urandom; emd_op = 2'(op); emd_start = 1'b1;
            tick();
            total++; if (ebusy !== 1'b0) begin bad++; $display("FAIL reserved_busy op=%0d: got %b want 0", op, ebusy); end
            total++; if ({hi, lo} !== {m_hi, m_lo}) begin bad++; $display("FAIL reserved_hilo op=%0d: got %h want %h", op, {hi, lo}, {m_hi, m_lo}); end
        end
        idle_inputs();
        a = $urandom; b = $urandom; pc = $urandom;
        r = md_ref(1'b0, a, b);
        ea = a; eb = b; epc4 = pc; ejal = 1'b1; emd_start = 1'b1; ern0 = 5'd3;
        #1;
        total++; if (ealu !== pc + 32'd4) begin bad++; $display("FAIL jal_start_link: got %h want %h", ealu, pc + 32'd4); end
        total++; if (ern !== 5'd31) begin bad++; $display("FAIL jal_start_ern: got %0d want 31", ern); end
        tick();
        idle_inputs();
        total++; if (ebusy !== 1'b1) begin bad++; $display("FAIL jal_start_busy: got %b want 1", ebusy); end
        wait_idle(n);
        total++; if ({hi, lo} !== r) begin bad++; $display("FAIL jal_start_result: got %h want %h", {hi, lo}, r); end
        m_hi = r[63:32];
        m_lo = r[31:0];
    endtask

    task automatic test_width16;
        int n;
        idle_inputs();
        a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        n = 0;
        while (ebusy16 && n < 100) begin
            tick();
            n++;
        end
        total++; if (n != 16) begin bad++; $display("FAIL w16_latency: got %0d want 16", n); end
        total++; if (hi16 !== 16'hFFFE) begin bad++; $display("FAIL w16_hi: got %h want fffe", hi16); end
        total++; if (lo16 !== 16'h0001) begin bad++; $display("FAIL w16_lo: got %h want 0001", lo16); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_alu_directed();
        test_multu_stall();
        test_md_random();
        test_alu_random();
        test_back_to_back();
        test_reset_abort();
        test_reserved_and_jal();
        test_alu_random();
        test_width16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeexe_md.md
# pipeexe_md

Parametrised execute stage for the five-stage pipelined CPU. Alongside the single-cycle ALU path and the jal link-address path, it adds an iterative multiply/divide unit with HI/LO registers, mfhi/mflo result selection, and a stall request to the pipeline control. It sits between the ID/EXE and EXE/MEM pipeline registers. All ALU, link and destination-register outputs remain combinational; only the multiply/divide unit is sequential.

## Interface
Parameters:
- WIDTH, 32: datapath width in bits; must be even and ≥8.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  stage clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ealuc  in  4  ALU operation code.
- ealuimm  in  1  selects eimm instead of eb as ALU operand b.
- eshift  in  1  selects esa instead of ea as ALU operand a.
- ejal  in  1  jal: forces ern to 31 and ealu to epc4+4.
- ea, eb, eimm, esa, epc4  in  WIDTH  operands, immediate, shift amount, PC+4.
- ern0  in  5  destination register number.
- emd_start  in  1  EXE holds a mult/div instruction.
- emd_op  in  2  00 MULTU, 01 DIVU, 1x reserved (ignored).
- emfhi, emflo  in  1  EXE holds mfhi / mflo.
- ealu  out  WIDTH  stage result.
- ern  out  5  final destination register.
- estall  out  1  stall request: freeze PC, IF/ID and ID/EXE, and insert a bubble into EXE/MEM.
- ebusy  out  1  multiply/divide unit busy.
- hi, lo  out  WIDTH  architectural HI/LO registers.

## Operation
- ALU operand a is esa if eshift=1, otherwise ea. Operand b is eimm if ealuimm=1, otherwise eb.
- ALU codes (x = don't care):
  - x000 add; x100 sub; x001 and; x101 or; x010 xor; x110 lui (b<<(WIDTH/2)).
  - 0011 sll; 0111 srl; 1111 sra. Shift amount is a[log2(WIDTH)-1:0].
  - All arithmetic is modulo 2^WIDTH; no overflow flag.
- Result priority: ejal → epc4+4; else emfhi → hi; else emflo → lo; else the ALU result.
- ern = ern0 | {5{ejal}}.
- Multiply/divide unit states:
  - IDLE → RUN when emd_start=1 and emd_op is 00 or 01. On entry, latch the operands from ea/eb, latch the op, and set count=0.
  - RUN: one iteration per cycle.
    - MULTU: shift-add, one multiplier bit per cycle.
    - DIVU: restoring divide, one quotient bit per cycle.
  - RUN → IDLE when count reaches WIDTH-1. On that edge, write {hi,lo}:
    - MULTU: the 2·WIDTH-bit product.
    - DIVU: hi=remainder, lo=quotient.
  - Divide by zero: hi=dividend, lo=all ones. The unit still takes WIDTH cycles.
  - Reserved emd_op values: no state change.
- ebusy = 1 exactly while in RUN.
- estall = ebusy & (emd_start | emfhi | emflo). It is combinational and never asserted while IDLE.
- While estall=1, the held instruction is not accepted. emd_start is re-evaluated every cycle.
- Reset: state=IDLE, count=0, hi=0, lo=0, ebusy=0, estall=0. Reset during RUN aborts the operation, and hi/lo are not updated with partial results.

## Timing
- ALU, link, mfhi/mflo select and ern have zero-cycle latency.
- Multiply/divide latency is WIDTH cycles:
  - emd_start is sampled at edge E0 (IDLE→RUN).
  - hi/lo update at edge E0+WIDTH; ebusy falls at the same edge.
  - An mfhi/mflo in the cycle after E0+WIDTH reads the new value without a stall.
- An mfhi/mflo arriving while busy stalls until that edge, then completes in the following cycle.
- A back-to-back emd_start while busy stalls. It is accepted on the first IDLE edge, with no idle gap.
- Simultaneous emd_start and ejal are a decode error. ealu still follows the result priority; the multiply/divide unit still starts.
- Independent ALU instructions flow without stalling while ebusy=1.

## Test plan
- ALU sweep (WIDTH=32): ea=0x0000_00F0, eb=0x0000_000F:
  - add → 0xFF; sub → 0xE1; or → 0xFF; and → 0x0.
  - sra with esa=4, eb=0x8000_0000 → 0xF800_0000.
  - ejal=1, epc4=0x100 → ealu=0x104, ern=31.
- MULTU: ea=0xFFFF_FFFF, eb=2, emd_start pulse, then mfhi held → estall=1 for 32 cycles, hi=0x1, lo=0xFFFF_FFFE, then ealu=0x1.
- DIVU: ea=100, eb=7 → after 32 cycles hi=2, lo=14. Divide by zero with ea=5, eb=0 → hi=5, lo=0xFFFF_FFFF.
- Overlap: issue MULTU, then ALU add 3+4 the next cycle → estall=0, ealu=7. A second MULTU while busy → estall held until the first completes, then starts with no gap.
- Reset at cycle 10 of a DIVU → hi=lo=0, ebusy=0 next cycle. A new MULTU 3×5 then gives lo=15.
- Parameter run WIDTH=16: MULTU 0xFFFF×0xFFFF → hi=0xFFFE, lo=0x0001 after exactly 16 cycles.
